write_resp_arbiter: RTL

WRITE_RESP_ARBITER -- requirements
Module: write_resp_arbiter

---
 rtl/write_resp_arbiter.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/write_resp_arbiter.sv
// rtl/write_resp_arbiter.sv - round-robin write-response arbiter with per-master split-write merging
// Optional counters: define WRITE_RESP_ARB_STATS_EN to add resp_cnt/err_cnt outputs.
module write_resp_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES  = 2,
    parameter int BID_W       = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_SLAVES*BID_W-1:0] m_bid,
    input  logic [NUM_SLAVES*2-1:0]   m_bresp,
    input  logic [NUM_SLAVES-1:0]     m_bvalid,
    output logic [NUM_SLAVES-1:0]     m_bready,
    output logic [NUM_MASTERS*2-1:0]  s_bresp,
    output logic [NUM_MASTERS-1:0]    s_bvalid,
    input  logic [NUM_MASTERS-1:0]    s_bready,
    input  logic                      split_load,
    input  logic [BID_W-1:0]          split_master,
    input  logic [3:0]                split_bursts,
`ifdef WRITE_RESP_ARB_STATS_EN
    output logic [15:0]               resp_cnt,
    output logic [15:0]               err_cnt,
`endif
    output logic                      bid_err
);
    localparam int SW = $clog2(NUM_SLAVES);

    typedef enum logic {IDLE, RESP} state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     last_grant_q, last_grant_d;
    logic [3:0]        rem_q [NUM_MASTERS];
    logic [3:0]        rem_d [NUM_MASTERS];
    logic [1:0]        acc_q [NUM_MASTERS];
    logic [1:0]        acc_d [NUM_MASTERS];
    logic [BID_W-1:0]  fwd_bid_q, fwd_bid_d;
    logic [1:0]        fwd_bresp_q, fwd_bresp_d;
    logic              bid_err_q, bid_err_d;

    logic              any_valid, hi_found, hs;
    logic [SW-1:0]     hi_idx, lo_idx, win;
    logic [BID_W-1:0]  cap_bid;
    logic [1:0]        cap_bresp, sel_acc, merged;
    logic [3:0]        sel_rem, sm_rem;
    logic              bid_ok, sm_ok;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        rem_d        = rem_q;
        acc_d        = acc_q;
        fwd_bid_d    = fwd_bid_q;
        fwd_bresp_d  = fwd_bresp_q;
        bid_err_d    = 1'b0;
        m_bready     = '0;
        s_bvalid     = '0;
        s_bresp      = '0;
        hs           = 1'b0;
        hi_found     = 1'b0;
        hi_idx       = '0;
        lo_idx       = '0;
        cap_bid      = '0;
        cap_bresp    = '0;
        sel_rem      = '0;
        sel_acc      = '0;
        bid_ok       = 1'b0;
        sm_rem       = '0;
        sm_ok        = 1'b0;
        any_valid    = |m_bvalid;

        // Descending scans leave the lowest matching index: first above last_grant, else lowest overall.
        for (int j = NUM_SLAVES - 1; j >= 0; j--) begin
            if (m_bvalid[j] && SW'(j) > last_grant_q) begin
                hi_found = 1'b1;
                hi_idx   = SW'(j);
            end
            if (m_bvalid[j]) lo_idx = SW'(j);
        end
        win = hi_found ? hi_idx : lo_idx;

        for (int j = 0; j < NUM_SLAVES; j++) begin
            if (win == SW'(j)) begin
                cap_bid   = m_bid[j*BID_W +: BID_W];
                cap_bresp = m_bresp[j*2 +: 2];
            end
        end

        for (int m = 0; m < NUM_MASTERS; m++) begin
            if (cap_bid == BID_W'(m)) begin
                bid_ok  = 1'b1;
                sel_rem = rem_q[m];
                sel_acc = acc_q[m];
            end
            if (split_master == BID_W'(m)) begin
                sm_ok  = 1'b1;
                sm_rem = rem_q[m];
            end
        end
        merged = (cap_bresp > sel_acc) ? cap_bresp : sel_acc;

        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    for (int j = 0; j < NUM_SLAVES; j++) m_bready[j] = (win == SW'(j));
                    last_grant_d = win;
                    if (!bid_ok) bid_err_d = 1'b1;
                    for (int m = 0; m < NUM_MASTERS; m++) begin
                        if (bid_ok && cap_bid == BID_W'(m)) begin
                            if (sel_rem >= 4'd2) begin
                                rem_d[m] = sel_rem - 4'd1;
                                acc_d[m] = merged;
                            end else begin
                                rem_d[m]    = '0;
                                acc_d[m]    = '0;
                                state_d     = RESP;
                                fwd_bid_d   = cap_bid;
                                fwd_bresp_d = (sel_rem == 4'd1) ? merged : cap_bresp;
                            end
                        end
                    end
                end
            end
            RESP: begin
                for (int m = 0; m < NUM_MASTERS; m++) begin
                    if (fwd_bid_q == BID_W'(m)) begin
                        s_bvalid[m]      = 1'b1;
                        s_bresp[m*2 +: 2] = fwd_bresp_q;
                        hs               = s_bready[m];
                    end
                end
                if (hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Load is judged on the pre-cycle table, so it overrides a same-cycle capture clear.
        if (split_load && sm_ok && sm_rem == 4'd0 && split_bursts >= 4'd2) begin
            for (int m = 0; m < NUM_MASTERS; m++) begin
                if (split_master == BID_W'(m)) begin
                    rem_d[m] = split_bursts;
                    acc_d[m] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= SW'(NUM_SLAVES - 1);
            fwd_bid_q    <= '0;
            fwd_bresp_q  <= '0;
            bid_err_q    <= 1'b0;
            for (int m = 0; m < NUM_MASTERS; m++) begin
                rem_q[m] <= '0;
                acc_q[m] <= '0;
            end
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            fwd_bid_q    <= fwd_bid_d;
            fwd_bresp_q  <= fwd_bresp_d;
            bid_err_q    <= bid_err_d;
            rem_q        <= rem_d;
            acc_q        <= acc_d;
        end
    end

    assign bid_err = bid_err_q;

`ifdef WRITE_RESP_ARB_STATS_EN
    logic [15:0] resp_cnt_q, err_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else if (hs) begin
            resp_cnt_q <= resp_cnt_q + 16'd1;
            if (fwd_bresp_q[1]) err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign resp_cnt = resp_cnt_q;
    assign err_cnt  = err_cnt_q;
`endif
endmodule
